// File: rtl/ssd_display_arbiter_if.sv
// Requester/display bundle for ssd_display_arbiter: request, value and mask inputs,
// grant/done handshake and the digit/mode drive toward the SSD controller.
interface ssd_display_arbiter_if;
    logic [3:0]  req;
    logic [15:0] value0;
    logic [15:0] value1;
    logic [15:0] value2;
    logic [15:0] value3;
    logic [3:0]  dmask0;
    logic [3:0]  dmask1;
    logic [3:0]  dmask2;
    logic [3:0]  dmask3;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic [3:0]  mode;
    logic        busy;

    modport master (
        output req, value0, value1, value2, value3,
        output dmask0, dmask1, dmask2, dmask3,
        input  grant, done, digit3, digit2, digit1, digit0, mode, busy
    );

    modport slave (
        input  req, value0, value1, value2, value3,
        input  dmask0, dmask1, dmask2, dmask3,
        output grant, done, digit3, digit2, digit1, digit0, mode, busy
    );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Round-robin time-sharing of one 4-digit SSD between four requesters.
// Define SSD_ARB_BLANK_EN to insert a dark BLANK interval of GAP_CYCLES after each image.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | display dark, no grant; arbitrate req from ptr upward each cycle
//   ST_SHOW  | winner's snapshot on display for HOLD_CYCLES cycles
//   ST_BLANK | display dark for GAP_CYCLES cycles (SSD_ARB_BLANK_EN only)
module ssd_display_arbiter #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 10_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    ssd_display_arbiter_if.slave        bus
);

    localparam int CNT_MAX = 134_217_727;

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX ||
        GAP_CYCLES < 1 || GAP_CYCLES > CNT_MAX) begin : g_param_check
        $error("ssd_display_arbiter: HOLD_CYCLES/GAP_CYCLES outside 1..2^27-1");
    end

    localparam logic [26:0] HOLD_LOAD = 27'(HOLD_CYCLES - 1);
`ifdef SSD_ARB_BLANK_EN
    localparam logic [26:0] GAP_LOAD  = 27'(GAP_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [26:0] cnt_q, cnt_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q, done_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  mode_q, mode_d;
    logic        busy_q, busy_d;

    logic        win_valid;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic [15:0] win_value;
    logic [3:0]  win_mask;

    // Scan downward so the last hit, i.e. the closest one at or after ptr, wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_value = bus.value0;
        win_mask  = bus.dmask0;
        case (win_idx)
            2'd0: begin win_value = bus.value0; win_mask = bus.dmask0; end
            2'd1: begin win_value = bus.value1; win_mask = bus.dmask1; end
            2'd2: begin win_value = bus.value2; win_mask = bus.dmask2; end
            default: begin win_value = bus.value3; win_mask = bus.dmask3; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_d   = 4'b0000;
        digits_d = digits_q;
        mode_d   = mode_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                mode_d  = 4'b0000;
                if (win_valid) begin
                    state_d  = ST_SHOW;
                    grant_d  = 4'b0001 << win_idx;
                    digits_d = win_value;
                    mode_d   = win_mask;
                    ptr_d    = win_idx + 2'd1;
                    cnt_d    = HOLD_LOAD;
                end
            end
            ST_SHOW: begin
                if (cnt_q == 27'd0) begin
                    done_d  = grant_q;
                    grant_d = 4'b0000;
                    mode_d  = 4'b0000;
`ifdef SSD_ARB_BLANK_EN
                    state_d = ST_BLANK;
                    cnt_d   = GAP_LOAD;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 27'd1;
                end
            end
            ST_BLANK: begin
`ifdef SSD_ARB_BLANK_EN
                if (cnt_q == 27'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 27'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                mode_d  = 4'b0000;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            cnt_q    <= 27'd0;
            grant_q  <= 4'b0000;
            done_q   <= 4'b0000;
            digits_q <= 16'h0000;
            mode_q   <= 4'b0000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.digit3 = digits_q[15:12];
    assign bus.digit2 = digits_q[11:8];
    assign bus.digit1 = digits_q[7:4];
    assign bus.digit0 = digits_q[3:0];
    assign bus.mode   = mode_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Self-checking bench for ssd_display_arbiter: vector table, directed corner sequences
// and randomized traffic against an image-schedule reference model.
module tb_ssd_display_arbiter;

    localparam int H = 4;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [15:0] val [4];
    logic [3:0]  msk [4];

    int n_pass  = 0;
    int n_total = 0;

    ssd_display_arbiter_if bus ();

    assign bus.req    = req;
    assign bus.value0 = val[0];
    assign bus.value1 = val[1];
    assign bus.value2 = val[2];
    assign bus.value3 = val[3];
    assign bus.dmask0 = msk[0];
    assign bus.dmask1 = msk[1];
    assign bus.dmask2 = msk[2];
    assign bus.dmask3 = msk[3];

    ssd_display_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  grant;
        logic [3:0]  done;
        logic [3:0]  mode;
        logic [15:0] digits;
        logic        busy;
    } out_t;

    // Reference: each granted image expands into the full list of output cycles it produces.
    out_t        sched [$];
    int          m_ptr = 0;
    logic [15:0] m_digits = 16'h0000;

    function automatic out_t mk(input logic [3:0] g, input logic [3:0] d, input logic [3:0] m,
                                input logic [15:0] dg, input logic b);
        out_t o;
        o.grant = g; o.done = d; o.mode = m; o.digits = dg; o.busy = b;
        return o;
    endfunction

    task automatic model_next(output out_t e);
        int k;
        if (rst) begin
            sched.delete();
            m_ptr    = 0;
            m_digits = 16'h0000;
            e        = '0;
            return;
        end
        if (sched.size() > 0) begin
            e = sched.pop_front();
            return;
        end
        k = -1;
        for (int j = 0; j < 4; j++)
            if (k < 0 && req[(m_ptr + j) % 4]) k = (m_ptr + j) % 4;
        if (k < 0) begin
            e = mk(4'b0000, 4'b0000, 4'b0000, m_digits, 1'b0);
            return;
        end
        m_digits = val[k];
        m_ptr    = (k + 1) % 4;
        e = mk(4'(1 << k), 4'b0000, msk[k], val[k], 1'b1);
        for (int j = 1; j < H; j++) sched.push_back(e);
`ifdef SSD_ARB_BLANK_EN
        sched.push_back(mk(4'b0000, 4'(1 << k), 4'b0000, m_digits, 1'b1));
        for (int j = 1; j < G; j++) sched.push_back(mk(4'b0000, 4'b0000, 4'b0000, m_digits, 1'b1));
        sched.push_back(mk(4'b0000, 4'b0000, 4'b0000, m_digits, 1'b0));
`else
        sched.push_back(mk(4'b0000, 4'(1 << k), 4'b0000, m_digits, 1'b0));
`endif
    endtask

    function automatic out_t dut_out();
        return mk(bus.grant, bus.done, bus.mode,
                  {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, bus.busy);
    endfunction

    task automatic check(input string nm, input logic [28:0] act, input logic [28:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input string nm);
        out_t e;
        model_next(e);
        @(posedge clk);
        #1;
        check(nm, 29'(dut_out()), 29'(e));
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        logic [15:0] exp_digits;
        logic [3:0]  exp_mode;
    } vec_t;

    vec_t vecs [6];

    int          gap_cnt;
    int          phase;
    logic [3:0]  prev_grant;
    logic [3:0]  gq [$];
    logic [3:0]  dq [$];

    initial begin
        for (int i = 0; i < 4; i++) begin val[i] = 16'h0000; msk[i] = 4'b0000; end

        vecs[0] = '{4'b0001, 4'b0001, 16'hC0DE, 4'b1111};
        vecs[1] = '{4'b0110, 4'b0010, 16'hBEEF, 4'b0011};
        vecs[2] = '{4'b1100, 4'b0100, 16'h1234, 4'b0101};
        vecs[3] = '{4'b1000, 4'b1000, 16'h9876, 4'b1000};
        vecs[4] = '{4'b1010, 4'b0010, 16'hBEEF, 4'b0011};
        vecs[5] = '{4'b1111, 4'b0001, 16'hC0DE, 4'b1111};

        // Reset and single request
        rst = 1'b1; step("reset");
        check("reset_outputs", 29'(dut_out()), 29'd0);
        rst = 1'b0;
        val[0] = 16'hA5C3; msk[0] = 4'b1111; req = 4'b0001;
        step("single_first");
        check("single_grant_digits_mode", {13'd0, bus.grant, bus.digit3, bus.digit2, bus.digit1, bus.digit0},
              {13'd0, 4'b0001, 16'hA5C3});
        req = 4'b0000;
        for (int i = 1; i < H; i++) step("single_show");
        step("single_done");
        check("single_done_pulse", {21'd0, bus.done, bus.mode}, {21'd0, 4'b0001, 4'b0000});
        for (int i = 0; i < 4; i++) step("single_tail");

        // Vector table: winner from reset pointer 0
        val[0] = 16'hC0DE; val[1] = 16'hBEEF; val[2] = 16'h1234; val[3] = 16'h9876;
        msk[0] = 4'b1111; msk[1] = 4'b0011; msk[2] = 4'b0101; msk[3] = 4'b1000;
        for (int v = 0; v < 6; v++) begin
            rst = 1'b1; req = 4'b0000; step("vec_reset");
            rst = 1'b0; req = vecs[v].req; step("vec_step");
            check($sformatf("vec%0d", v),
                  {5'd0, bus.grant, bus.mode, bus.digit3, bus.digit2, bus.digit1, bus.digit0},
                  {5'd0, vecs[v].exp_grant, vecs[v].exp_mode, vecs[v].exp_digits});
        end

        // Round robin with all four requesting
        rst = 1'b1; req = 4'b0000; step("rr_reset");
        rst = 1'b0; req = 4'b1111;
        prev_grant = 4'b0000;
        gq.delete(); dq.delete();
        for (int i = 0; i < 40; i++) begin
            step("rr_cycle");
            if (bus.grant != 4'b0000 && prev_grant == 4'b0000) gq.push_back(bus.grant);
            if (bus.done != 4'b0000) dq.push_back(bus.done);
            prev_grant = bus.grant;
        end
        check("rr_grant_count_ge5", 29'(gq.size() >= 5), 29'd1);
        check("rr_done_count_ge4", 29'(dq.size() >= 4), 29'd1);
        if (gq.size() >= 5)
            check("rr_grant_order", {9'd0, gq[0], gq[1], gq[2], gq[3], gq[4]},
                  {9'd0, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001});
        if (dq.size() >= 4)
            check("rr_done_order", {13'd0, dq[0], dq[1], dq[2], dq[3]},
                  {13'd0, 4'b0001, 4'b0010, 4'b0100, 4'b1000});

        // Snapshot: value and request change during SHOW are ignored
        rst = 1'b1; req = 4'b0000; step("snap_reset");
        rst = 1'b0; val[2] = 16'h1234; req = 4'b0100; step("snap_first");
        val[2] = 16'hFFFF; req = 4'b0000;
        for (int i = 1; i < H; i++) begin
            step("snap_show");
            check("snap_digits", {13'd0, bus.digit3, bus.digit2, bus.digit1, bus.digit0}, {13'd0, 16'h1234});
        end
        step("snap_done");
        check("snap_done_pulse", {25'd0, bus.done}, {25'd0, 4'b0100});

        // Dark interval between images
        rst = 1'b1; step("gap_reset");
        rst = 1'b0; req = 4'b0011;
        phase = 0; gap_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step("gap_cycle");
            case (phase)
                0: if (bus.grant == 4'b0001) phase = 1;
                1: if (bus.grant == 4'b0000) begin phase = 2; gap_cnt = (bus.mode == 4'b0000) ? 1 : 0; end
                2: if (bus.grant == 4'b0010) phase = 3;
                   else if (bus.mode == 4'b0000) gap_cnt++;
                default: ;
            endcase
        end
        check("gap_reached_second_grant", 29'(phase), 29'd3);
`ifdef SSD_ARB_BLANK_EN
        check("gap_dark_cycles", 29'(gap_cnt), 29'(G + 1));
`else
        check("gap_dark_cycles", 29'(gap_cnt), 29'd1);
`endif

        // Reset in the 2nd SHOW cycle of requester 3
        rst = 1'b1; req = 4'b0000; step("mid_reset_pre");
        rst = 1'b0; req = 4'b1000; step("mid_show1");
        step("mid_show2");
        rst = 1'b1; step("mid_reset");
        check("mid_reset_outputs", 29'(dut_out()), 29'd0);
        rst = 1'b0; req = 4'b1001; step("mid_after");
        check("mid_after_grant", {25'd0, bus.grant}, {25'd0, 4'b0001});
        req = 4'b0000;
        for (int i = 0; i < H + G + 2; i++) step("mid_tail");

        // Partial digit mask
        rst = 1'b1; step("mask_reset");
        rst = 1'b0; val[1] = 16'h00BE; msk[1] = 4'b0011; req = 4'b0010; step("mask_first");
        check("mask_mode_digits", {17'd0, bus.mode, bus.digit1, bus.digit0}, {17'd0, 4'b0011, 4'hB, 4'hE});
        req = 4'b0000;
        for (int i = 0; i < H + G + 2; i++) step("mask_tail");

        // Randomized traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int j = 0; j < 4; j++) begin
                val[j] = 16'($urandom());
                msk[j] = 4'($urandom_range(0, 15));
            end
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
